inv_delay_sequencer: RTL and testbench

Digital sequencer for the on-chip analog inverter. It drives the inverter input with a square wave of programmable half-period. It samples the digitised inverter output through a 2-FF synchroniser and measures, for each stimulus edge, the clk cycles until the inverter responds. Delays over NEDGE edges are accumulated into one result word. Sits in the tt_um top beside the analog macro: stim_out routes to the inverter input, inv_in comes from the output buffer/comparator.

---
 rtl/inv_delay_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_inv_delay_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_delay_sequencer.sv
// Inverter delay sequencer: drives a square-wave stimulus into the analog
// inverter, measures the per-edge response latency through a 2-FF
// synchroniser and accumulates it (saturating) over NEDGE stimulus edges.
module inv_delay_sequencer #(
  parameter int HALF_W = 8,
  parameter int ACC_W  = 16,
  parameter int NEDGE  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [HALF_W-1:0] half_period,
  input  logic              inv_in,
  output logic              stim_out,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic [ACC_W-1:0]  result
);

  localparam int EDGE_W = (NEDGE > 1) ? $clog2(NEDGE) : 1;
  localparam int SUM_W  = ((ACC_W > HALF_W) ? ACC_W : HALF_W) + 1;

  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(NEDGE - 1);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);
  localparam logic [HALF_W-1:0] HP_MIN    = HALF_W'(4);
  localparam logic [HALF_W-1:0] CNT_ONE   = HALF_W'(1);
  localparam logic [ACC_W-1:0]  ACC_MAX   = {ACC_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q, sync_d;
  logic                stim_q, stim_d;
  logic                busy_q, busy_d;
  logic                tmo_q, tmo_d;
  logic [ACC_W-1:0]    result_q, result_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [HALF_W-1:0]   hp_q, hp_d;
  logic [HALF_W-1:0]   cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;

  logic                inv_s;
  logic                resp;
  logic                hp_elapsed;
  logic                advance;
  logic [SUM_W-1:0]    sum;
  logic [ACC_W-1:0]    acc_sat;
  logic [HALF_W-1:0]   hp_clamp;

  assign inv_s       = sync_q[1];
  assign stim_out    = stim_q;
  assign busy        = busy_q;
  assign done        = (state_q == S_DONE);
  assign timeout_err = tmo_q;
  assign result      = result_q;

  // Synchroniser shift for the asynchronous inverter output.
  always_comb begin
    sync_d = {sync_q[0], inv_in};
  end

  // Next-state and datapath: settle, measure each edge, hold to the next toggle.
  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    busy_d   = busy_q;
    tmo_d    = tmo_q;
    result_d = result_q;
    acc_d    = acc_q;
    hp_d     = hp_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    advance  = 1'b0;

    // Inverter has answered once its synchronised output opposes the stimulus.
    resp       = (inv_s == ~stim_q);
    sum        = SUM_W'(acc_q) + SUM_W'(cnt_q);
    acc_sat    = (sum > SUM_W'(ACC_MAX)) ? ACC_MAX : sum[ACC_W-1:0];
    // cnt counts cycles since the last toggle; at HP-1 the next toggle is due.
    hp_elapsed = (cnt_q >= (hp_q - CNT_ONE));
    hp_clamp   = (half_period < HP_MIN) ? HP_MIN : half_period;

    if ((state_q != S_IDLE) && !ena) begin
      // Abort: silent return to idle, result and error flag left alone.
      state_d = S_IDLE;
      stim_d  = 1'b0;
      busy_d  = 1'b0;
      cnt_d   = '0;
      edge_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          stim_d = 1'b0;
          if (start && ena) begin
            hp_d    = hp_clamp;
            acc_d   = '0;
            edge_d  = '0;
            cnt_d   = '0;
            tmo_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_SETTLE;
          end
        end
        S_SETTLE: begin
          cnt_d = cnt_q + CNT_ONE;
          if (hp_elapsed) begin
            if (!inv_s) begin
              // Inverter output never rose with a low input: stuck or absent.
              tmo_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              stim_d  = 1'b1;
              cnt_d   = '0;
              state_d = S_MEASURE;
            end
          end
        end
        S_MEASURE: begin
          cnt_d = cnt_q + CNT_ONE;
          if (resp) begin
            // A response on the HP cycle still counts; it beats the timeout.
            acc_d = acc_sat;
            if (hp_elapsed) advance = 1'b1;
            else            state_d = S_HOLD;
          end else if (cnt_q == hp_q) begin
            tmo_d   = 1'b1;
            state_d = S_DONE;
          end
        end
        S_HOLD: begin
          cnt_d = cnt_q + CNT_ONE;
          if (hp_elapsed) advance = 1'b1;
        end
        S_DONE: begin
          stim_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Next stimulus edge, or finish once all edges have been measured.
    if (advance) begin
      if (edge_q == LAST_EDGE) begin
        state_d = S_DONE;
      end else begin
        edge_d  = edge_q + EDGE_ONE;
        stim_d  = ~stim_q;
        cnt_d   = '0;
        state_d = S_MEASURE;
      end
    end

    // Publish the (possibly partial) sum on the same cycle done is raised.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      result_d = acc_d;
      stim_d   = 1'b0;
    end
  end

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      stim_q   <= 1'b0;
      busy_q   <= 1'b0;
      tmo_q    <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      hp_q     <= '0;
      cnt_q    <= '0;
      edge_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      stim_q   <= stim_d;
      busy_q   <= busy_d;
      tmo_q    <= tmo_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      hp_q     <= hp_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
    end
  end

endmodule

// File: tb/tb_inv_delay_sequencer.sv
// Directed bench for inv_delay_sequencer with a cycle-delayed inverter model.
module tb_inv_delay_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, ena, start, start2;
  logic [7:0]  half_period;
  logic        inv_in, inv_in2;
  logic        stim_out, busy, done, timeout_err;
  logic [15:0] result;
  logic        stim_out2, busy2, done2, timeout_err2;
  logic [5:0]  result2;

  int total = 0;
  int bad   = 0;

  // Inverter model controls
  int          dly = 0;
  logic        force_en = 1'b0;
  logic        force_val = 1'b0;
  logic [15:0] dl, dl2;

  // Capture results
  int          cap_ntog, cap_first, cap_badsp, cap_done_cyc, cap_ndone, cap_busy_bad;
  logic [15:0] cap_res;
  logic        cap_tmo;

  always #5 clk = ~clk;

  inv_delay_sequencer #(.HALF_W(8), .ACC_W(16), .NEDGE(16)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .half_period(half_period),
    .inv_in(inv_in), .stim_out(stim_out), .busy(busy), .done(done),
    .timeout_err(timeout_err), .result(result));

  inv_delay_sequencer #(.HALF_W(8), .ACC_W(6), .NEDGE(16)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start2), .half_period(half_period),
    .inv_in(inv_in2), .stim_out(stim_out2), .busy(busy2), .done(done2),
    .timeout_err(timeout_err2), .result(result2));

  always @(posedge clk) begin
    dl  <= {dl[14:0], ~stim_out};
    dl2 <= {dl2[14:0], ~stim_out2};
  end

  always_comb begin
    if (force_en)      inv_in = force_val;
    else if (dly == 0) inv_in = ~stim_out;
    else               inv_in = dl[dly-1];
  end

  assign inv_in2 = dl2[2];

  task automatic do_start(input logic [7:0] hp);
    @(posedge clk); #1;
    half_period = hp;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records stimulus edges, done pulses and busy behaviour from cycle 1 (first SETTLE cycle).
  task automatic capture(input int hp, input int max_cyc, input int inj);
    logic prev;
    int   last;
    int   cyc;
    prev = stim_out; last = 0; cyc = 0;
    cap_ntog = 0; cap_first = 0; cap_badsp = 0; cap_done_cyc = 0;
    cap_ndone = 0; cap_busy_bad = 0; cap_res = '0; cap_tmo = 1'b0;
    while ((cyc < max_cyc) && !((cap_ndone > 0) && (cyc >= cap_done_cyc + 2))) begin
      @(negedge clk);
      cyc++;
      if (inj > 0) begin
        if (cyc == inj) begin start = 1'b1; half_period = 8'd50; end
        else if (cyc == inj + 1) start = 1'b0;
      end
      if (stim_out !== prev) begin
        cap_ntog++;
        if (cap_ntog == 1) cap_first = cyc;
        else if (cyc - last != hp) cap_badsp++;
        last = cyc;
        prev = stim_out;
      end
      if (done === 1'b1) begin
        cap_ndone++;
        cap_done_cyc = cyc;
        cap_res = result;
        cap_tmo = timeout_err;
        if (busy !== 1'b1) cap_busy_bad++;
      end else if ((cap_ndone == 0) && (busy !== 1'b1)) cap_busy_bad++;
      else if ((cap_ndone > 0) && (busy !== 1'b0)) cap_busy_bad++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; start2 = 1'b0; half_period = 8'd0;
    repeat (4) @(negedge clk);
    total++; if ({stim_out, busy, done, timeout_err} !== 4'b0) begin bad++;
      $display("FAIL reset_flags: got %b want 0000", {stim_out, busy, done, timeout_err}); end
    total++; if (result !== 16'd0) begin bad++; $display("FAIL reset_result: got %0d want 0", result); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ({busy, done, stim_out} !== 3'b0) begin bad++;
      $display("FAIL idle_after_reset: got %b want 000", {busy, done, stim_out}); end
  endtask

  task automatic test_zero_delay;
    dly = 0;
    do_start(8'd10);
    capture(10, 400, 0);
    total++; if (cap_ntog !== 16) begin bad++; $display("FAIL zd_toggles: got %0d want 16", cap_ntog); end
    total++; if (cap_first !== 11) begin bad++; $display("FAIL zd_first_toggle: got %0d want 11", cap_first); end
    total++; if (cap_badsp !== 0) begin bad++; $display("FAIL zd_spacing: got %0d bad gaps want 0", cap_badsp); end
    total++; if (cap_ndone !== 1) begin bad++; $display("FAIL zd_done_count: got %0d want 1", cap_ndone); end
    total++; if (cap_done_cyc !== 171) begin bad++; $display("FAIL zd_done_cycle: got %0d want 171", cap_done_cyc); end
    total++; if (cap_res !== 16'd32) begin bad++; $display("FAIL zd_result: got %0d want 32", cap_res); end
    total++; if (cap_tmo !== 1'b0) begin bad++; $display("FAIL zd_timeout: got %b want 0", cap_tmo); end
    total++; if (cap_busy_bad !== 0) begin bad++; $display("FAIL zd_busy: got %0d bad cycles want 0", cap_busy_bad); end
  endtask

  task automatic test_delay5;
    dly = 5;
    repeat (10) @(negedge clk);
    do_start(8'd20);
    capture(20, 800, 0);
    total++; if (cap_ntog !== 16) begin bad++; $display("FAIL d5_toggles: got %0d want 16", cap_ntog); end
    total++; if (cap_first !== 21) begin bad++; $display("FAIL d5_first_toggle: got %0d want 21", cap_first); end
    total++; if (cap_badsp !== 0) begin bad++; $display("FAIL d5_spacing: got %0d bad gaps want 0", cap_badsp); end
    total++; if (cap_done_cyc !== 341) begin bad++; $display("FAIL d5_done_cycle: got %0d want 341", cap_done_cyc); end
    total++; if (cap_res !== 16'd112) begin bad++; $display("FAIL d5_result: got %0d want 112", cap_res); end
    dly = 0;
  endtask

  task automatic test_stuck_high;
    force_en = 1'b1; force_val = 1'b1;
    repeat (5) @(negedge clk);
    do_start(8'd10);
    capture(10, 100, 0);
    total++; if (cap_first !== 11) begin bad++; $display("FAIL sh_first_toggle: got %0d want 11", cap_first); end
    total++; if ((cap_ndone !== 1) || (cap_done_cyc !== 22)) begin bad++;
      $display("FAIL sh_done: got count %0d cycle %0d want 1 at 22", cap_ndone, cap_done_cyc); end
    total++; if (cap_tmo !== 1'b1) begin bad++; $display("FAIL sh_timeout: got %b want 1", cap_tmo); end
    total++; if (cap_res !== 16'd0) begin bad++; $display("FAIL sh_result: got %0d want 0", cap_res); end
    total++; if (stim_out !== 1'b0) begin bad++; $display("FAIL sh_stim_low: got %b want 0", stim_out); end
  endtask

  task automatic test_stuck_low;
    force_en = 1'b1; force_val = 1'b0;
    repeat (5) @(negedge clk);
    do_start(8'd10);
    capture(10, 100, 0);
    total++; if (cap_ntog !== 0) begin bad++; $display("FAIL sl_toggles: got %0d want 0", cap_ntog); end
    total++; if ((cap_ndone !== 1) || (cap_done_cyc !== 11)) begin bad++;
      $display("FAIL sl_done: got count %0d cycle %0d want 1 at 11", cap_ndone, cap_done_cyc); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL sl_timeout: got %b want 1", timeout_err); end
    force_en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_clamp_busy_start;
    bit seen;
    do_start(8'd2);
    capture(4, 200, 20);
    total++; if (cap_first !== 5) begin bad++; $display("FAIL cl_first_toggle: got %0d want 5", cap_first); end
    total++; if ((cap_ntog !== 16) || (cap_badsp !== 0)) begin bad++;
      $display("FAIL cl_toggles: got %0d edges %0d bad gaps want 16 and 0", cap_ntog, cap_badsp); end
    total++; if (cap_done_cyc !== 69) begin bad++; $display("FAIL cl_done_cycle: got %0d want 69", cap_done_cyc); end
    total++; if (cap_res !== 16'd32) begin bad++; $display("FAIL cl_result: got %0d want 32", cap_res); end
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (busy || done) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL cl_no_restart: got activity %b want 0", seen); end
  endtask

  task automatic test_ena_abort;
    bit seen;
    do_start(8'd10);
    repeat (15) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    total++; if ({busy, stim_out} !== 2'b00) begin bad++;
      $display("FAIL ab_idle: got busy,stim %b want 00", {busy, stim_out}); end
    seen = 1'b0;
    repeat (20) begin @(negedge clk); if (done) seen = 1'b1; end
    ena = 1'b1;
    repeat (30) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL ab_no_done: got activity %b want 0", seen); end
    total++; if (result !== 16'd32) begin bad++; $display("FAIL ab_result_kept: got %0d want 32", result); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL ab_timeout_kept: got %b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid_run;
    bit seen;
    do_start(8'd10);
    repeat (13) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if ({stim_out, busy, done, timeout_err} !== 4'b0) begin bad++;
      $display("FAIL rm_flags: got %b want 0000", {stim_out, busy, done, timeout_err}); end
    total++; if (result !== 16'd0) begin bad++; $display("FAIL rm_result: got %0d want 0", result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (done || busy) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rm_no_done: got activity %b want 0", seen); end
  endtask

  task automatic test_saturation;
    int cyc;
    bit got;
    logic [5:0] r;
    @(posedge clk); #1;
    half_period = 8'd10;
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    got = 1'b0; cyc = 0; r = '0;
    while (!got && (cyc < 400)) begin
      @(negedge clk); cyc++;
      if (done2) begin got = 1'b1; r = result2; end
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL sat_done: got none within %0d cycles", cyc); end
    total++; if (r !== 6'd63) begin bad++; $display("FAIL sat_result: got %0d want 63", r); end
    total++; if (timeout_err2 !== 1'b0) begin bad++; $display("FAIL sat_timeout: got %b want 0", timeout_err2); end
    @(negedge clk);
    total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL sat_busy_drop: got %b want 0", busy2); end
  endtask

  initial begin
    test_reset();
    test_zero_delay();
    test_delay5();
    test_stuck_high();
    test_stuck_low();
    test_clamp_busy_start();
    test_ena_abort();
    test_reset_mid_run();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
